fifo_n_count: RTL and testbench

Parametrised-depth synchronous FIFO, the general successor to the fixed two-entry FIFO used throughout the BSV primitive library.
- Same ENQ/DEQ/FULL_N/EMPTY_N/CLR handshake as the existing primitives, so generated code can instantiate it as a drop-in.
- Adds:
  - arbitrary depth
  - occupancy count
  - registered almost-full flag
  - sticky overflow/underflow error flag, visible in synthesis (not just simulation)
- Sits between BSV-generated rule logic and any producer/consumer needing more than two entries of elasticity.

---
 rtl/fifo_n_count_pkg.sv | 22 ++
 rtl/fifo_n_count_mem.sv | 27 ++
 rtl/fifo_n_count.sv | 102 ++++++++++
 tb/tb_fifo_n_count.sv | 193 +++++++++++++++++++
 4 files changed

// File: rtl/fifo_n_count_pkg.sv
// rtl/fifo_n_count_pkg.sv - shared types and helpers for the counted fifo
package fifo_n_count_pkg;

    typedef enum logic [1:0] {
        OP_NONE = 2'b00,
        OP_DEQ  = 2'b01,
        OP_ENQ  = 2'b10,
        OP_BOTH = 2'b11
    } fifo_op_e;

    // Explicit wrap so non-power-of-2 depths never rely on pointer overflow.
    function automatic logic [31:0] ptr_inc(input logic [31:0] p, input int unsigned d);
        return (p == d - 32'd1) ? 32'd0 : p + 32'd1;
    endfunction

    function automatic bit params_ok(input int unsigned depth, input int unsigned cntw,
                                     input int unsigned afull);
        return (depth >= 2) && (depth <= 1024) && (cntw < 31) &&
               ((32'd1 << cntw) > depth) && (afull >= 1) && (afull <= depth);
    endfunction

endpackage

// File: rtl/fifo_n_count_mem.sv
// rtl/fifo_n_count_mem.sv - register-array storage, sync write, async read
module fifo_n_count_mem
    import fifo_n_count_pkg::*;
#(
    parameter int unsigned width = 1,
    parameter int unsigned depth = 4,
    parameter int unsigned aw    = 2
) (
    input  logic             clk,
    input  logic             we,
    input  logic [aw-1:0]    waddr,
    input  logic [width-1:0] wdata,
    input  logic [aw-1:0]    raddr,
    output logic [width-1:0] rdata
);

    logic [width-1:0] mem [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/fifo_n_count.sv
// rtl/fifo_n_count.sv - parametrised-depth fifo with count, almost-full and sticky error
module fifo_n_count
    import fifo_n_count_pkg::*;
#(
    parameter int unsigned width   = 1,
    parameter int unsigned depth   = 4,
    parameter int unsigned cntw    = 3,
    parameter int unsigned afull   = 3,
    parameter int unsigned guarded = 1
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic [width-1:0] D_IN,
    input  logic             ENQ,
    output logic             FULL_N,
    input  logic             DEQ,
    output logic [width-1:0] D_OUT,
    output logic             EMPTY_N,
    input  logic             CLR,
    output logic [cntw-1:0]  COUNT,
    output logic             ALMOST_FULL_N,
    output logic             ERR
);

    localparam int unsigned aw = $clog2(depth);

    if (!params_ok(depth, cntw, afull)) begin : g_bad_params
        $error("fifo_n_count: illegal depth/cntw/afull combination");
    end

    logic [aw-1:0]   head_q, tail_q;
    logic [cntw-1:0] count_q, count_nxt;
    logic            full_n_q, empty_n_q, afull_n_q, err_q;
    logic            enq_ok, deq_ok;
    fifo_op_e        op;

    // Unguarded mode lets a full fifo accept ENQ when a DEQ frees the head slot.
    assign deq_ok = DEQ & empty_n_q;
    assign enq_ok = ENQ & (full_n_q | ((guarded == 0) & deq_ok));
    assign op     = fifo_op_e'({enq_ok, deq_ok});

    always_comb begin
        count_nxt = count_q;
        case (op)
            OP_ENQ:  count_nxt = count_q + cntw'(1);
            OP_DEQ:  count_nxt = count_q - cntw'(1);
            default: count_nxt = count_q;
        endcase
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
            afull_n_q <= 1'b1;
            err_q     <= 1'b0;
        end else if (CLR) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            full_n_q  <= 1'b1;
            empty_n_q <= 1'b0;
            afull_n_q <= 1'b1;
            err_q     <= 1'b0;
        end else begin
            if (enq_ok) begin
                tail_q <= aw'(ptr_inc(32'(tail_q), depth));
            end
            if (deq_ok) begin
                head_q <= aw'(ptr_inc(32'(head_q), depth));
            end
            count_q   <= count_nxt;
            empty_n_q <= (count_nxt != '0);
            full_n_q  <= (count_nxt != cntw'(depth));
            afull_n_q <= (count_nxt < cntw'(afull));
            err_q     <= err_q | (ENQ & ~enq_ok) | (DEQ & ~deq_ok);
        end
    end

    fifo_n_count_mem #(
        .width (width),
        .depth (depth),
        .aw    (aw)
    ) u_mem (
        .clk   (CLK),
        .we    (enq_ok & ~CLR),
        .waddr (tail_q),
        .wdata (D_IN),
        .raddr (head_q),
        .rdata (D_OUT)
    );

    assign FULL_N        = full_n_q;
    assign EMPTY_N       = empty_n_q;
    assign ALMOST_FULL_N = afull_n_q;
    assign COUNT         = count_q;
    assign ERR           = err_q;

endmodule

// File: tb/tb_fifo_n_count.sv
// tb/tb_fifo_n_count.sv - directed self-checking bench for fifo_n_count
module tb_fifo_n_count;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clr = 1'b0;
    logic [7:0] din = 8'h00;

    // g: depth 4 guarded, u: depth 4 unguarded, t: depth 3 guarded
    logic       g_enq = 1'b0, g_deq = 1'b0, g_full_n, g_empty_n, g_afull_n, g_err;
    logic [7:0] g_dout;
    logic [2:0] g_count;
    logic       u_enq = 1'b0, u_deq = 1'b0, u_full_n, u_empty_n, u_afull_n, u_err;
    logic [7:0] u_dout;
    logic [2:0] u_count;
    logic       t_enq = 1'b0, t_deq = 1'b0, t_full_n, t_empty_n, t_afull_n, t_err;
    logic [7:0] t_dout;
    logic [1:0] t_count;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    fifo_n_count #(.width(8), .depth(4), .cntw(3), .afull(3), .guarded(1)) u_g4 (
        .CLK(clk), .RST_N(rst_n), .D_IN(din), .ENQ(g_enq), .FULL_N(g_full_n),
        .DEQ(g_deq), .D_OUT(g_dout), .EMPTY_N(g_empty_n), .CLR(clr),
        .COUNT(g_count), .ALMOST_FULL_N(g_afull_n), .ERR(g_err)
    );

    fifo_n_count #(.width(8), .depth(4), .cntw(3), .afull(3), .guarded(0)) u_u4 (
        .CLK(clk), .RST_N(rst_n), .D_IN(din), .ENQ(u_enq), .FULL_N(u_full_n),
        .DEQ(u_deq), .D_OUT(u_dout), .EMPTY_N(u_empty_n), .CLR(clr),
        .COUNT(u_count), .ALMOST_FULL_N(u_afull_n), .ERR(u_err)
    );

    fifo_n_count #(.width(8), .depth(3), .cntw(2), .afull(3), .guarded(1)) u_d3 (
        .CLK(clk), .RST_N(rst_n), .D_IN(din), .ENQ(t_enq), .FULL_N(t_full_n),
        .DEQ(t_deq), .D_OUT(t_dout), .EMPTY_N(t_empty_n), .CLR(clr),
        .COUNT(t_count), .ALMOST_FULL_N(t_afull_n), .ERR(t_err)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        // reset and idle
        #12;
        chk("rst_empty_n", 32'(g_empty_n), 0);
        chk("rst_full_n",  32'(g_full_n), 1);
        chk("rst_count",   32'(g_count), 0);
        chk("rst_err",     32'(g_err), 0);
        chk("rst_afull_n", 32'(g_afull_n), 1);
        rst_n = 1'b1;
        cyc();
        cyc();
        chk("idle_count", 32'(g_count), 0);

        // fill depth 4 with A1..A4
        g_enq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 8'hA1 + 8'(i);
            cyc();
            chk("fill_count",   32'(g_count), 32'(i + 1));
            chk("fill_afull_n", 32'(g_afull_n), (i + 1 < 3) ? 1 : 0);
            chk("fill_full_n",  32'(g_full_n), (i < 3) ? 1 : 0);
            chk("fill_head",    32'(g_dout), 32'hA1);
        end
        g_enq = 1'b0;
        g_deq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            chk("drain_data", 32'(g_dout), 32'hA1 + 32'(i));
            cyc();
            chk("drain_count", 32'(g_count), 32'(3 - i));
        end
        g_deq = 1'b0;
        chk("drain_empty_n", 32'(g_empty_n), 0);
        chk("drain_err",     32'(g_err), 0);

        // guarded: full + ENQ/DEQ rejects the ENQ
        g_enq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 8'h30 + 8'(i);
            cyc();
        end
        chk("gfull_full_n", 32'(g_full_n), 0);
        g_deq = 1'b1;
        din = 8'hB0;
        cyc();
        g_enq = 1'b0;
        g_deq = 1'b0;
        chk("gboth_err",   32'(g_err), 1);
        chk("gboth_count", 32'(g_count), 3);
        chk("gboth_head",  32'(g_dout), 32'h31);

        // CLR wins over a simultaneous ENQ
        clr = 1'b1;
        g_enq = 1'b1;
        din = 8'hC0;
        cyc();
        clr = 1'b0;
        g_enq = 1'b0;
        chk("clr_count",   32'(g_count), 0);
        chk("clr_empty_n", 32'(g_empty_n), 0);
        chk("clr_err",     32'(g_err), 0);
        chk("clr_full_n",  32'(g_full_n), 1);
        cyc();
        chk("clr_drop",    32'(g_count), 0);

        // empty + ENQ/DEQ: DEQ rejected, ENQ lands
        g_enq = 1'b1;
        g_deq = 1'b1;
        din = 8'h5A;
        cyc();
        g_deq = 1'b0;
        chk("eboth_err",     32'(g_err), 1);
        chk("eboth_count",   32'(g_count), 1);
        chk("eboth_dout",    32'(g_dout), 32'h5A);
        chk("eboth_empty_n", 32'(g_empty_n), 1);

        // async reset mid-stream with count 3
        din = 8'h5B;
        cyc();
        din = 8'h5C;
        cyc();
        g_enq = 1'b0;
        chk("pre_rst_count", 32'(g_count), 3);
        rst_n = 1'b0;
        #2;
        chk("arst_count",   32'(g_count), 0);
        chk("arst_empty_n", 32'(g_empty_n), 0);
        chk("arst_full_n",  32'(g_full_n), 1);
        chk("arst_err",     32'(g_err), 0);
        chk("arst_afull_n", 32'(g_afull_n), 1);
        #10;
        rst_n = 1'b1;
        cyc();

        // unguarded: full + ENQ/DEQ accepted
        u_enq = 1'b1;
        for (int i = 0; i < 4; i++) begin
            din = 8'h11 + 8'(i);
            cyc();
        end
        chk("ufull_full_n", 32'(u_full_n), 0);
        u_deq = 1'b1;
        din = 8'h15;
        cyc();
        u_enq = 1'b0;
        chk("uboth_count",  32'(u_count), 4);
        chk("uboth_err",    32'(u_err), 0);
        chk("uboth_full_n", 32'(u_full_n), 0);
        for (int i = 0; i < 4; i++) begin
            chk("udrain_data", 32'(u_dout), 32'h12 + 32'(i));
            cyc();
        end
        u_deq = 1'b0;
        chk("udrain_empty_n", 32'(u_empty_n), 0);

        // depth 3: steady-state ENQ/DEQ at count 2 wraps pointers
        t_enq = 1'b1;
        din = 8'h20;
        cyc();
        din = 8'h21;
        cyc();
        chk("d3_prime_count", 32'(t_count), 2);
        t_deq = 1'b1;
        for (int r = 0; r < 10; r++) begin
            chk("d3_head", 32'(t_dout), 32'h20 + 32'(r));
            din = 8'h22 + 8'(r);
            cyc();
            chk("d3_count", 32'(t_count), 2);
        end
        t_enq = 1'b0;
        t_deq = 1'b0;
        chk("d3_err",  32'(t_err), 0);
        chk("d3_tail", 32'(t_dout), 32'h2A);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
